// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_state_e : control states of the LSU sequencer
//   F3_*        : RV32I funct3 encodings for memory access size/sign
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_R,
    WB,
    ERR
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit (32-bit only).
//   is_store, funct3, addr_lo : operation kind, size/sign and byte offset
//   store_data                : rs2 value to be written
//   rdata                     : word returned by data memory
//   wstrb, wdata              : byte enables and lane-replicated store data
//   load_data                 : selected and extended load result
//   misalign                  : access is misaligned or funct3 is illegal
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] rdata_shifted;

  // Store side: strobes and data replication; illegal encodings fall
  // through to misalign=1 so they take the error path.
  always_comb begin
    wstrb    = 4'b0000;
    wdata    = store_data;
    misalign = 1'b1;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          wstrb    = 4'b0001 << addr_lo;
          wdata    = {4{store_data[7:0]}};
          misalign = 1'b0;
        end
        F3_H: begin
          wstrb    = 4'b0011 << addr_lo;
          wdata    = {2{store_data[15:0]}};
          misalign = addr_lo[0];
        end
        F3_W: begin
          wstrb    = 4'b1111;
          misalign = |addr_lo;
        end
        default: ;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: misalign = 1'b0;
        F3_H, F3_HU: misalign = addr_lo[0];
        F3_W:        misalign = |addr_lo;
        default:     ;
      endcase
    end
  end

  // Bring the addressed byte/half down to bit 0, then extend.
  assign rdata_shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      F3_BU: load_data = {24'h000000, rdata_shifted[7:0]};
      F3_H:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      F3_HU: load_data = {16'h0000, rdata_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one memory op at a time from execute,
// issues a word-aligned request over req/gnt/rvalid, and writes aligned,
// extended load data to the register file.
//   clk, reset (async, active-low)
//   req_valid/req_ready, is_store, funct3, addr, store_data, rd_addr : core side
//   mem_req/we/addr/wstrb/wdata, mem_gnt, mem_rvalid, mem_rdata      : memory side
//   RegWrite, W_Add, W_Data                                           : regfile write
//   done, misalign_err                                                : retire status
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int Width     = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [AddrWidth-1:0] addr,
  input  logic [Width-1:0]     store_data,
  input  logic [4:0]           rd_addr,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [3:0]           mem_wstrb,
  output logic [Width-1:0]     mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [Width-1:0]     mem_rdata,
  output logic                 RegWrite,
  output logic [4:0]           W_Add,
  output logic [Width-1:0]     W_Data,
  output logic                 done,
  output logic                 misalign_err
);

  lsu_state_e           state_q, state_d;
  logic                 is_store_q, is_store_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [Width-1:0]     sdata_q, sdata_d;
  logic [4:0]           rd_q, rd_d;
  logic                 reg_write_q, reg_write_d;
  logic [4:0]           w_add_q, w_add_d;
  logic [Width-1:0]     w_data_q, w_data_d;

  logic                 in_idle;
  logic                 accept;
  logic                 op_is_store;
  logic [2:0]           op_funct3;
  logic [1:0]           op_addr_lo;
  logic [Width-1:0]     op_sdata;
  logic [3:0]           al_wstrb;
  logic [Width-1:0]     al_wdata;
  logic [Width-1:0]     al_load;
  logic                 al_misalign;

  assign in_idle   = (state_q == IDLE);
  // Ready falls with reset even though the state is already IDLE.
  assign req_ready = in_idle & reset;
  assign accept    = req_valid & req_ready;

  // One aligner serves both phases: live inputs for the misalign decision at
  // accept, latched fields afterwards for strobes, data and load extraction.
  assign op_is_store = in_idle ? is_store          : is_store_q;
  assign op_funct3   = in_idle ? funct3            : funct3_q;
  assign op_addr_lo  = in_idle ? addr[1:0]         : addr_q[1:0];
  assign op_sdata    = in_idle ? store_data        : sdata_q;

  lsu_align u_align (
    .is_store   (op_is_store),
    .funct3     (op_funct3),
    .addr_lo    (op_addr_lo),
    .store_data (op_sdata),
    .rdata      (mem_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misalign   (al_misalign)
  );

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    rd_d        = rd_q;
    reg_write_d = 1'b0;
    w_add_d     = 5'd0;
    w_data_d    = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          addr_d     = addr;
          sdata_d    = store_data;
          rd_d       = rd_addr;
          state_d    = al_misalign ? ERR : REQ;
        end
      end
      REQ: begin
        // rvalid in this state belongs to nothing and is dropped.
        if (mem_gnt) state_d = is_store_q ? IDLE : WAIT_R;
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          state_d = WB;
          // x0 writes are suppressed entirely so the port stays all-zero.
          if (rd_q != 5'd0) begin
            reg_write_d = 1'b1;
            w_add_d     = rd_q;
            w_data_d    = al_load;
          end
        end
      end
      WB:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= '0;
      sdata_q     <= '0;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      w_add_q     <= 5'd0;
      w_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      w_add_q     <= w_add_d;
      w_data_q    <= w_data_d;
    end
  end

  // Memory outputs are held from latched fields for the whole REQ phase.
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & is_store_q;
  assign mem_addr  = mem_req ? {addr_q[AddrWidth-1:2], 2'b00} : '0;
  assign mem_wstrb = mem_req ? al_wstrb : 4'b0000;
  assign mem_wdata = mem_req ? al_wdata : '0;

  assign RegWrite     = reg_write_q;
  assign W_Add        = w_add_q;
  assign W_Data       = w_data_q;
  // A store retires in its grant cycle; loads retire in WB, errors in ERR.
  assign done         = (state_q == WB) | (state_q == ERR) |
                        (mem_req & is_store_q & mem_gnt);
  assign misalign_err = (state_q == ERR);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        RegWrite;
  logic [4:0]  W_Add;
  logic [31:0] W_Data;
  logic        done;
  logic        misalign_err;

  load_store_unit #(.Width(32), .AddrWidth(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .rd_addr(rd_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .RegWrite(RegWrite), .W_Add(W_Add), .W_Data(W_Data),
    .done(done), .misalign_err(misalign_err)
  );

  typedef struct {
    bit          err;
    bit          rw;
    bit [4:0]    wadd;
    bit [31:0]   wdata;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   retired = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: legality and alignment from the RV32I rules.
  function automatic bit model_err(input bit st, input bit [2:0] f3, input bit [31:0] a);
    int unsigned size;
    if (st) begin
      if (!(f3 inside {F3_B, F3_H, F3_W})) return 1'b1;
    end else begin
      if (!(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) return 1'b1;
    end
    size = (f3 == F3_B || f3 == F3_BU) ? 1 : (f3 == F3_W) ? 4 : 2;
    return (a % size) != 0;
  endfunction

  // Reference: pick byte/half by lane number and extend with arithmetic.
  function automatic bit [31:0] model_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] w);
    int unsigned lane;
    int unsigned v;
    bit [31:0]   r;
    lane = a % 4;
    r = w;
    if (f3 == F3_B || f3 == F3_BU) begin
      v = (w >> (8 * lane)) & 255;
      r = (f3 == F3_B && v >= 128) ? v - 256 : v;
    end else if (f3 == F3_H || f3 == F3_HU) begin
      v = (w >> (8 * lane)) & 65535;
      r = (f3 == F3_H && v >= 32768) ? v - 65536 : v;
    end
    return r;
  endfunction

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_issue", 32'(req_ready), 32'd1);
  endtask

  // Issue one op, act as the memory, and check the memory-side fields.
  task automatic run_op(input bit st, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] sd, input bit [4:0] rd,
                        input bit [31:0] rdata, input int gd, input int rv);
    exp_t        e;
    int unsigned size;
    bit [3:0]    strb;
    bit [31:0]   wd;
    wait_ready();
    e.err  = model_err(st, f3, a);
    e.rw   = !e.err && !st && rd != 5'd0;
    e.wadd = e.rw ? rd : 5'd0;
    e.wdata = e.rw ? model_load(f3, a, rdata) : 32'd0;
    e.done_cyc = cyc + 1 + (e.err ? 0 : (st ? gd : gd + rv + 1));
    exp_q.push_back(e);
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a;
    store_data = sd; rd_addr = rd;
    @(negedge clk);
    // Busy: scramble inputs, they must be ignored.
    req_valid = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; store_data = $urandom; rd_addr = 5'($urandom);
    if (e.err) begin
      chk("err_no_mem_req", 32'(mem_req), 32'd0);
      @(negedge clk);
    end else begin
      size = (f3 == F3_B) ? 1 : (f3 == F3_W) ? 4 : 2;
      strb = st ? 4'(((1 << size) - 1) << (a % 4)) : 4'd0;
      wd = (size == 1) ? (sd & 255) * 32'h01010101 :
           (size == 2) ? (sd & 65535) * 32'h00010001 : sd;
      for (int c = 0; c <= gd; c++) begin
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("mem_addr", mem_addr, a & ~32'd3);
        chk("mem_we", 32'(mem_we), 32'(st));
        chk("mem_wstrb", 32'(mem_wstrb), 32'(strb));
        if (st) chk("mem_wdata", mem_wdata, wd);
        mem_gnt = (c == gd);
        // Spurious rvalid alongside gnt must be ignored.
        mem_rvalid = (c == gd) && !st && ($urandom_range(0, 1) == 1);
        mem_rdata = $urandom;
        @(negedge clk);
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!st) begin
        repeat (rv - 1) begin
          chk("mem_req_dropped", 32'(mem_req), 32'd0);
          @(negedge clk);
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT retires an op.
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          retired++;
          chk("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
          chk("misalign_err", 32'(misalign_err), 32'(mon_e.err));
          chk("RegWrite", 32'(RegWrite), 32'(mon_e.rw));
          chk("W_Add", 32'(W_Add), 32'(mon_e.wadd));
          chk("W_Data", W_Data, mon_e.wdata);
          $display("op %0d retired at cycle %0d: err=%0d regwrite=%0d rd=%0d data=0x%08h",
                   retired, cyc, misalign_err, RegWrite, W_Add, W_Data);
        end
      end else begin
        chk("quiet_outputs", W_Data | 32'(W_Add) | 32'(RegWrite) | 32'(misalign_err), 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; store_data = 32'd0; rd_addr = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    #12;
    chk("reset_outputs", 32'({req_ready, mem_req, mem_we, mem_wstrb, RegWrite, W_Add, done, misalign_err})
        | mem_addr | mem_wdata | W_Data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Directed cases.
    run_op(1'b0, F3_W,  32'h100, 32'd0, 5'd5, 32'hDEADBEEF, 0, 1);
    run_op(1'b0, F3_B,  32'h103, 32'd0, 5'd6, 32'h80FF0000, 0, 1);
    run_op(1'b0, F3_BU, 32'h103, 32'd0, 5'd6, 32'h80FF0000, 1, 2);
    run_op(1'b0, F3_HU, 32'h102, 32'd0, 5'd6, 32'h80FF0000, 0, 1);
    run_op(1'b1, F3_B,  32'h201, 32'h000000AB, 5'd0, 32'd0, 4, 1);
    run_op(1'b1, F3_W,  32'h302, 32'h12345678, 5'd0, 32'd0, 0, 1);
    run_op(1'b0, F3_H,  32'h101, 32'd0, 5'd9, 32'h11223344, 0, 1);
    run_op(1'b0, F3_W,  32'h400, 32'd0, 5'd0, 32'hCAFEF00D, 0, 1);
    run_op(1'b1, F3_H,  32'h502, 32'h0000BEEF, 5'd0, 32'd0, 2, 1);

    // Reset while waiting for read data; the op must vanish.
    wait_ready();
    req_valid = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h40; rd_addr = 5'd7;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("midop_reset_outputs", 32'({req_ready, mem_req, RegWrite, W_Add, done, misalign_err}) | W_Data, 32'd0);
    @(negedge clk);
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (3) begin
      chk("late_rvalid_no_write", 32'(RegWrite), 32'd0);
      chk("ready_after_midop_reset", 32'(req_ready), 32'd1);
      @(negedge clk);
    end

    // Randomized ops.
    for (int n = 0; n < 250; n++) begin
      run_op(1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom),
             $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
    end

    repeat (5) @(negedge clk);
    chk("pending_ops", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
